cart_burst_reader: RTL and testbench

Autonomous GBA ROM burst reader and the parametrised successor to the single-step, SPI-commanded cartridge controller. The host issues one command (start address, word count); the block sequences CS/RD/AD itself with programmable RD-low time. Read words go through an internal FIFO with valid/ready backpressure. It sits between the SPI command decoder and the cartridge pins (SB_IO tristate at top level).

---
 rtl/cart_burst_reader.sv | 156 +++++++++++++++
 tb/tb_cart_burst_reader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_burst_reader.sv
// Autonomous GBA ROM burst reader: one command sequences CS/RD/AD and streams words through a FIFO.
// Optional ABORT input enabled by defining CART_READER_ABORT_EN.
module cart_burst_reader #(
  parameter int ADDR_W     = 24,
  parameter int LEN_W      = 16,
  parameter int RD_WAIT    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [ADDR_W-1:0]  i_cmd_addr,
  input  logic [LEN_W-1:0]   i_cmd_len,
  output logic               o_data_valid,
  input  logic               i_data_ready,
  output logic [15:0]        o_data,
  output logic               o_busy,
  output logic               o_cs,
  output logic               o_rd,
  output logic               o_wr,
  output logic               o_ad_oe,
  output logic [15:0]        o_ad_out,
  input  logic [15:0]        i_ad_in,
`ifdef CART_READER_ABORT_EN
  input  logic               i_abort,
`endif
  output logic [ADDR_W-17:0] o_a_hi
);

  localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT - 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LATCH, S_TURN, S_RD_LOW, S_SAMPLE, S_GAP, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [WAIT_W-1:0]   r_wait;
  logic [15:0]         r_capture;

  logic [15:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wrPtr;
  logic [PTR_W-1:0]    r_rdPtr;
  logic [PTR_W:0]      r_count;

  logic                w_abort;
  logic                w_flush;
  logic                w_full;
  logic                w_push;
  logic                w_pop;

`ifdef CART_READER_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_flush = w_abort && (r_state != S_IDLE);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = o_data_valid && i_data_ready;
  assign w_push  = (r_state == S_SAMPLE) && (!w_full || w_pop);

  // Pins decode straight from the state so an async reset returns them at once.
  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_busy       = r_state inside {S_SETUP, S_LATCH, S_TURN, S_RD_LOW, S_SAMPLE, S_GAP};
  assign o_cs         = !(r_state inside {S_LATCH, S_TURN, S_RD_LOW, S_SAMPLE, S_GAP});
  assign o_rd         = (r_state != S_RD_LOW);
  assign o_wr         = 1'b1;
  assign o_ad_oe      = (r_state == S_SETUP) || (r_state == S_LATCH);
  assign o_ad_out     = r_addr[15:0];
  assign o_a_hi       = r_addr[ADDR_W-1:16];
  assign o_data_valid = (r_count != '0);
  assign o_data       = r_mem[r_rdPtr];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_cmd_valid) w_next = (i_cmd_len == '0) ? S_DONE : S_SETUP;
      S_SETUP:  w_next = S_LATCH;
      S_LATCH:  w_next = S_TURN;
      S_TURN:   w_next = S_RD_LOW;
      S_RD_LOW: if (r_wait == WAIT_LAST) w_next = S_SAMPLE;
      S_SAMPLE: w_next = S_GAP;
      // The cartridge only counts the low 16 bits, so a page wrap needs a fresh latch.
      S_GAP: begin
        if (r_len == '0)                w_next = S_DONE;
        else if (w_full)                w_next = S_GAP;
        else if (r_addr[15:0] == 16'h0) w_next = S_SETUP;
        else                            w_next = S_RD_LOW;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_flush) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_wait    <= '0;
      r_capture <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_cmd_valid) begin
        r_addr <= i_cmd_addr;
        r_len  <= i_cmd_len;
      end
      if (r_state == S_RD_LOW) begin
        r_wait <= r_wait + 1'b1;
        if (r_wait == WAIT_LAST) begin
          r_wait    <= '0;
          r_capture <= i_ad_in;
        end
      end else begin
        r_wait <= '0;
      end
      if (r_state == S_SAMPLE) begin
        r_addr <= r_addr + 1'b1;
        r_len  <= r_len - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wrPtr] <= r_capture;
  end

endmodule

// File: tb/tb_cart_burst_reader.sv
// Randomized bench for cart_burst_reader: a cartridge pin model feeds AD_IN and a queue scoreboard checks data.
// Exercises the abort path too when CART_READER_ABORT_EN is defined.
module tb_cart_burst_reader;

  localparam int ADDR_W     = 24;
  localparam int LEN_W      = 16;
  localparam int RD_WAIT    = 2;
  localparam int FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rstN = 1'b1;
  logic              cmdValid = 1'b0;
  logic              cmdReady;
  logic [23:0]       cmdAddr = '0;
  logic [15:0]       cmdLen = '0;
  logic              dataValid;
  logic              dataReady = 1'b0;
  logic [15:0]       dataOut;
  logic              busy;
  logic              aCs;
  logic              aRd;
  logic              aWr;
  logic              aAdOe;
  logic [15:0]       adOut;
  logic [15:0]       adIn;
  logic [7:0]        aHi;
`ifdef CART_READER_ABORT_EN
  logic              abort = 1'b0;
`endif

  cart_burst_reader #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_WAIT(RD_WAIT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(clk), .i_reset_n(rstN),
    .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady),
    .i_cmd_addr(cmdAddr), .i_cmd_len(cmdLen),
    .o_data_valid(dataValid), .i_data_ready(dataReady), .o_data(dataOut),
    .o_busy(busy), .o_cs(aCs), .o_rd(aRd), .o_wr(aWr),
    .o_ad_oe(aAdOe), .o_ad_out(adOut), .i_ad_in(adIn),
`ifdef CART_READER_ABORT_EN
    .i_abort(abort),
`endif
    .o_a_hi(aHi)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Cartridge: latches the address on CS fall, bumps only the low 16 bits on each RD rise.
  function automatic logic [15:0] wordOf(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], 8'h00};
  endfunction

  logic [23:0] cartAddr = '0;
  logic        useFixed = 1'b0;
  logic [15:0] fixedWord = 16'h0;
  assign adIn = useFixed ? fixedWord : wordOf(cartAddr);

  always @(negedge aCs) cartAddr = {aHi, adOut};
  always @(posedge aRd) if (aCs === 1'b0) cartAddr[15:0] = cartAddr[15:0] + 16'd1;

  logic [15:0] expQ[$];
  logic [23:0] latchQ[$];
  int  cycle = 0, rdFalls = 0, csFalls = 0, rdLowLen = 0, lastFall = 0;
  int  expFalls = 0, curLen = 0, readyMode = 1;
  bit  prevRd = 1'b1, prevCs = 1'b1, skipPinChecks = 1'b1, checkSpacing = 1'b0;

  // Pin protocol monitor: latch address, RD width and spacing, CS low around RD.
  always @(negedge clk) begin
    cycle++;
    if (!skipPinChecks) begin
      if (prevCs && !aCs) begin
        csFalls++;
        checkOutput("latchOe", aAdOe, 1);
        if (latchQ.size() == 0) checkOutput("latchAddrExtra", {aHi, adOut}, 32'hFFFF_FFFF);
        else                    checkOutput("latchAddr", {aHi, adOut}, latchQ.pop_front());
      end
      if (prevRd && !aRd) begin
        rdFalls++;
        checkOutput("csDuringRd", aCs, 0);
        if (checkSpacing && rdFalls > 1) checkOutput("rdSpacing", cycle - lastFall, RD_WAIT + 2);
        lastFall = cycle;
      end
      if (!aRd) rdLowLen++;
      else if (!prevRd) begin
        checkOutput("rdWidth", rdLowLen, RD_WAIT);
        rdLowLen = 0;
      end
    end
    prevRd = aRd;
    prevCs = aCs;
  end

  // Consumer: picks DATA_READY for the coming edge, then checks the word that edge pops.
  always @(negedge clk) begin
    case (readyMode)
      0:       dataReady = 1'b0;
      1:       dataReady = 1'b1;
      default: dataReady = ($urandom_range(0, 1) == 1);
    endcase
    if (rstN && dataValid && dataReady) begin
      if (expQ.size() == 0) checkOutput("dataExtra", dataOut, 32'hFFFF_FFFF);
      else                  checkOutput("data", dataOut, expQ.pop_front());
    end
  end

  task automatic applyStimulus(input logic [23:0] addr, input int len, input bit checkLat);
    int guard;
    int lat;
    logic [23:0] a;
    @(negedge clk);
    guard = 0;
    while (!cmdReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmdReady) checkOutput("cmdReadyWait", cmdReady, 1);
    rdFalls  = 0;
    csFalls  = 0;
    curLen   = len;
    expFalls = (len > 0) ? 1 : 0;
    for (int i = 0; i < len; i++) begin
      a = addr + 24'(i);
      expQ.push_back(useFixed ? fixedWord : wordOf(a));
      if (i == 0 || a[15:0] == 16'h0) latchQ.push_back(a);
      if (i > 0 && a[15:0] == 16'h0) expFalls++;
    end
    cmdValid = 1'b1;
    cmdAddr  = addr;
    cmdLen   = len[15:0];
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
    cmdAddr  = 24'($urandom);
    if (checkLat) begin
      lat = 1;
      while (!dataValid && lat < 30) begin
        @(negedge clk);
        lat++;
      end
      checkOutput("firstWordLat", lat - 1, RD_WAIT + 4);
    end
  endtask

  task automatic waitDone();
    int guard;
    bit done;
    guard = 0;
    done = 1'b0;
    while (!done && guard < 3000) begin
      @(negedge clk);
      #1;
      done = cmdReady && (expQ.size() == 0) && !dataValid;
      guard++;
    end
    checkOutput("burstTimeout", done, 1);
    checkOutput("rdPulses", rdFalls, curLen);
    checkOutput("csFalls", csFalls, expFalls);
    checkOutput("latchLeft", latchQ.size(), 0);
    checkOutput("busyAfter", busy, 0);
  endtask

  task automatic waitRdWord3();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (!(rdFalls >= 3 && !aRd) && guard < 200);
    checkOutput("reachWord3", (rdFalls >= 3 && !aRd), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] ra;
    int rl;
    #1 rstN = 1'b0;
    #2;
    checkOutput("rstCs", aCs, 1);
    checkOutput("rstRd", aRd, 1);
    checkOutput("rstWr", aWr, 1);
    checkOutput("rstAdOe", aAdOe, 0);
    checkOutput("rstAdOut", adOut, 0);
    checkOutput("rstAHi", aHi, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDataValid", dataValid, 0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    skipPinChecks = 1'b0;
    checkOutput("rstCmdReady", cmdReady, 1);

    $display("[TB] single read");
    readyMode = 1;
    useFixed  = 1'b1;
    fixedWord = 16'hBEEF;
    applyStimulus(24'h000100, 1, 1'b1);
    waitDone();
    useFixed = 1'b0;

    $display("[TB] burst of 4");
    checkSpacing = 1'b1;
    applyStimulus(24'h000010, 4, 1'b0);
    waitDone();
    checkSpacing = 1'b0;

    $display("[TB] backpressure");
    readyMode = 0;
    applyStimulus(24'h000200, 12, 1'b0);
    repeat (45) @(negedge clk);
    cmdValid = 1'b1;
    cmdAddr  = 24'h777777;
    cmdLen   = 16'd3;
    repeat (3) @(negedge clk);
    cmdValid = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    checkOutput("bpRdPulses", rdFalls, FIFO_DEPTH);
    checkOutput("bpCsLow", aCs, 0);
    checkOutput("bpRdHigh", aRd, 1);
    checkOutput("bpBusy", busy, 1);
    checkOutput("bpDataValid", dataValid, 1);
    readyMode = 1;
    waitDone();

    $display("[TB] page wrap");
    applyStimulus(24'h01FFFE, 4, 1'b0);
    waitDone();

    $display("[TB] zero length");
    applyStimulus(24'h001234, 0, 1'b0);
    checkOutput("len0Busy", busy, 0);
    checkOutput("len0Cs", aCs, 1);
    @(negedge clk);
    checkOutput("len0Ready", cmdReady, 1);
    waitDone();

    $display("[TB] random bursts");
    readyMode = 2;
    for (int n = 0; n < 8; n++) begin
      ra = 24'($urandom);
      if ($urandom_range(0, 1) == 1) ra[15:0] = 16'hFFFF - 16'($urandom_range(0, 4));
      if (n == 7) ra = 24'hFFFFFD;
      rl = $urandom_range(1, 20);
      applyStimulus(ra, rl, 1'b0);
      waitDone();
    end

    $display("[TB] reset during word 3");
    readyMode = 1;
    applyStimulus(24'h003000, 6, 1'b0);
    waitRdWord3();
    skipPinChecks = 1'b1;
    rstN = 1'b0;
    #1;
    checkOutput("midRstCs", aCs, 1);
    checkOutput("midRstRd", aRd, 1);
    checkOutput("midRstAdOe", aAdOe, 0);
    checkOutput("midRstDataValid", dataValid, 0);
    checkOutput("midRstBusy", busy, 0);
    expQ.delete();
    latchQ.delete();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    rdLowLen = 0;
    skipPinChecks = 1'b0;
    checkOutput("midRstCmdReady", cmdReady, 1);
    applyStimulus(24'h0040F0, 5, 1'b0);
    waitDone();

`ifdef CART_READER_ABORT_EN
    $display("[TB] abort during word 3");
    applyStimulus(24'h005000, 6, 1'b0);
    waitRdWord3();
    skipPinChecks = 1'b1;
    abort = 1'b1;
    checkOutput("abortBeforeEdge", aCs, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abortCs", aCs, 1);
    checkOutput("abortRd", aRd, 1);
    checkOutput("abortAdOe", aAdOe, 0);
    checkOutput("abortDataValid", dataValid, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortCmdReady", cmdReady, 1);
    expQ.delete();
    latchQ.delete();
    @(negedge clk);
    rdLowLen = 0;
    skipPinChecks = 1'b0;
    applyStimulus(24'h0060A0, 7, 1'b0);
    waitDone();
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
